// File: rtl/kypd_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its debounce FSM.
package kypd_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kypd_state_e;

  // Outcome of one full four-column scan.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } scan_res_e;

  // Key map: nibble {row, col} holds the hex legend printed on that key.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  // Hex legend of the key at (row, col).
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

  // Index of the single asserted bit in an active-high row vector.
  function automatic logic [1:0] row_index(input logic [3:0] low);
    logic [1:0] idx;
    case (low)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when more than one row is pulled low in the same column.
  function automatic logic multi_low(input logic [3:0] low);
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Press/release debouncer: steps once per full-scan result and produces the
// accepted key code, a one-cycle press pulse and a held flag.
module keypad_debounce_fsm
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_scan_stb,
  input  scan_res_e i_scan_res,
  input  logic [3:0] i_scan_code,
  output logic [3:0] o_key_code,
  output logic      o_key_valid,
  output logic      o_key_down
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  kypd_state_e r_state, w_state_nxt;
  logic [3:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_key_code, w_code_nxt;
  logic        r_key_valid, w_valid_nxt;
  logic        r_key_down, w_down_nxt;
  logic [3:0]  w_cnt_inc;
  logic        w_same;

  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_same    = (i_scan_res == KEY) && (i_scan_code == r_cand);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_down  <= w_down_nxt;
    end
  end

  // Next-state logic; only a scan strobe can move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = r_key_down;
    if (i_scan_stb) begin
      case (r_state)
        IDLE: begin
          if (i_scan_res == KEY) begin
            w_cand_nxt = i_scan_code;
            w_cnt_nxt  = 4'd1;
            if (DS == 4'd1) begin
              w_state_nxt = PRESSED;
              w_code_nxt  = i_scan_code;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DEBOUNCE: begin
          if (w_same) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DS) begin
              w_state_nxt = PRESSED;
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end else if (i_scan_res == KEY) begin
            w_cand_nxt = i_scan_code;
            w_cnt_nxt  = 4'd1;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        PRESSED: begin
          if (w_same) begin
            w_state_nxt = PRESSED;
          end else if (i_scan_res == NONE) begin
            if (DS == 4'd1) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 4'd0;
              w_down_nxt  = 1'b0;
            end else begin
              w_state_nxt = RELEASE;
              w_cnt_nxt   = 4'd1;
            end
          end else begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = 4'd0;
          end
        end
        RELEASE: begin
          if (i_scan_res == NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DS) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 4'd0;
              w_down_nxt  = 1'b0;
            end else begin
              w_state_nxt = RELEASE;
            end
          end else if (w_same) begin
            w_state_nxt = PRESSED;
          end else begin
            w_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized rows at the end of each column dwell, classifies each full
// scan and hands the result to the debounce FSM.
module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int CNT_BITS       = 17,
  parameter int SCAN_CYCLE     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(SCAN_CYCLE - 1);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  logic [3:0]          r_row_meta, r_row_sync;
  logic [CNT_BITS-1:0] r_cnt;
  logic [1:0]          r_col_idx;
  logic [3:0]          r_col_n;
  logic                r_acc_hit, r_acc_multi;
  logic [3:0]          r_acc_code;

  logic                w_sample;
  logic [1:0]          w_col_idx_nxt;
  logic [3:0]          w_low;
  logic                w_col_none, w_col_multi;
  logic [3:0]          w_col_code;
  logic                w_hit_nxt, w_multi_nxt;
  logic [3:0]          w_code_nxt;
  logic                w_scan_stb;
  scan_res_e           w_scan_res;

  // Two-flop synchronizer on the asynchronous keypad rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= row_n;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_sample      = (r_cnt == LAST);
  assign w_col_idx_nxt = r_col_idx + 2'd1;
  assign w_low         = ~r_row_sync;
  assign w_col_none    = (w_low == 4'd0);
  assign w_col_multi   = multi_low(w_low);
  assign w_col_code    = key_lookup(row_index(w_low), r_col_idx);

  // Fold the current column sample into the running scan accumulator.
  always_comb begin
    w_hit_nxt   = r_acc_hit;
    w_multi_nxt = r_acc_multi;
    w_code_nxt  = r_acc_code;
    if (w_col_multi) begin
      w_multi_nxt = 1'b1;
    end else if (!w_col_none) begin
      if (r_acc_hit) begin
        w_multi_nxt = 1'b1;
      end else begin
        w_hit_nxt  = 1'b1;
        w_code_nxt = w_col_code;
      end
    end else begin
      w_hit_nxt = r_acc_hit;
    end
  end

  // The last column's sample closes the scan; the result goes straight to the FSM.
  assign w_scan_stb = w_sample && (r_col_idx == 2'd3);
  assign w_scan_res = w_multi_nxt ? MULTI : (w_hit_nxt ? KEY : NONE);

  // Column dwell counter, column drive and per-scan accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_col_n     <= 4'b1110;
      r_acc_hit   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_code  <= 4'd0;
    end else if (w_sample) begin
      r_cnt     <= '0;
      r_col_idx <= w_col_idx_nxt;
      r_col_n   <= ~(4'b0001 << w_col_idx_nxt);
      if (r_col_idx == 2'd3) begin
        r_acc_hit   <= 1'b0;
        r_acc_multi <= 1'b0;
        r_acc_code  <= 4'd0;
      end else begin
        r_acc_hit   <= w_hit_nxt;
        r_acc_multi <= w_multi_nxt;
        r_acc_code  <= w_code_nxt;
      end
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign col_n = r_col_n;

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_scan_stb (w_scan_stb),
    .i_scan_res (w_scan_res),
    .i_scan_code(w_code_nxt),
    .o_key_code (key_code),
    .o_key_valid(key_valid),
    .o_key_down (key_down)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: models the key matrix, queues the
// expected key code for every press it expects to be accepted, and a
// separate monitor checks each key_valid pulse against the queue.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = 16'h0000;   // bit {row,col} set while that key is held

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;

  always #5 clk = ~clk;

  keypad_scanner #(
    .CNT_BITS      (4),
    .SCAN_CYCLE    (8),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every press pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got key_valid=1 code=%0h expected no pulse", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse_code", {28'd0, key_code}, {28'd0, mon_exp});
        check("pulse_down", {31'd0, key_down}, 32'd1);
        check("pulse_align", {28'd0, col_n}, 32'h0000000E);
      end
    end
  end

  // Advance to the first cycle of the next full scan (col_n 0111 -> 1110).
  task automatic next_scan();
    logic [3:0] prev;
    bit found;
    prev  = col_n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = col_n;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout: got no scan boundary expected one within 40 clks");
    end
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) next_scan();
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col_n}, 32'hE);
    check("rst_code", {28'd0, key_code}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_down", {31'd0, key_down}, 32'd0);
    rst = 1'b1;

    // Idle for 20 scans: column walk every 8 clks
    for (int k = 0; k < 640; k++) begin
      exp_col = ~(one << ((k / 8) % 4));
      check("idle_col", {28'd0, col_n}, {28'd0, exp_col});
      @(negedge clk);
    end
    check("idle_down", {31'd0, key_down}, 32'd0);

    // Hold "6": one pulse after the third scan, then release
    next_scan();
    pressed = 16'h0040;
    exp_q.push_back(4'h6);
    scans(2);
    check("k6_not_yet", exp_q.size(), 32'd1);
    next_scan();
    pressed = 16'h0000;
    repeat (2) @(negedge clk);
    check("k6_taken", exp_q.size(), 32'd0);
    check("k6_down", {31'd0, key_down}, 32'd1);
    check("k6_code", {28'd0, key_code}, 32'h6);
    scans(2);
    check("k6_rel_hold", {31'd0, key_down}, 32'd1);
    next_scan();
    repeat (2) @(negedge clk);
    check("k6_released", {31'd0, key_down}, 32'd0);
    check("k6_code_kept", {28'd0, key_code}, 32'h6);

    // Bounce "5" five times, then hold it
    next_scan();
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0020;
      next_scan();
      pressed = 16'h0000;
      next_scan();
    end
    check("k5_bounce_down", {31'd0, key_down}, 32'd0);
    pressed = 16'h0020;
    exp_q.push_back(4'h5);
    scans(3);
    repeat (2) @(negedge clk);
    check("k5_taken", exp_q.size(), 32'd0);
    check("k5_code", {28'd0, key_code}, 32'h5);
    pressed = 16'h0000;
    scans(3);
    repeat (2) @(negedge clk);
    check("k5_released", {31'd0, key_down}, 32'd0);

    // "1" and "9" together: MULTI every scan, no press
    next_scan();
    pressed = 16'h0401;
    scans(4);
    check("multi_down", {31'd0, key_down}, 32'd0);
    pressed = 16'h0000;
    next_scan();

    // "D" held, then "0" added on the same row, then clean "D" again
    pressed = 16'h8000;
    exp_q.push_back(4'hD);
    scans(3);
    repeat (2) @(negedge clk);
    check("kD_taken", exp_q.size(), 32'd0);
    check("kD_code", {28'd0, key_code}, 32'hD);
    next_scan();
    pressed = 16'h9000;
    next_scan();
    pressed = 16'h8000;
    check("kD0_down", {31'd0, key_down}, 32'd1);
    next_scan();
    check("kD_back_down", {31'd0, key_down}, 32'd1);
    scans(2);
    check("kD_hold_down", {31'd0, key_down}, 32'd1);
    pressed = 16'h0000;
    scans(3);
    repeat (2) @(negedge clk);
    check("kD_released", {31'd0, key_down}, 32'd0);

    // "A" for 2 scans, then "B" for 3 scans: only B accepted
    next_scan();
    pressed = 16'h0008;
    scans(2);
    pressed = 16'h0080;
    exp_q.push_back(4'hB);
    scans(3);
    repeat (2) @(negedge clk);
    check("kB_taken", exp_q.size(), 32'd0);
    check("kB_code", {28'd0, key_code}, 32'hB);
    pressed = 16'h0000;
    scans(3);
    repeat (2) @(negedge clk);
    check("kB_released", {31'd0, key_down}, 32'd0);

    // Reset in the middle of debouncing "7"
    next_scan();
    pressed = 16'h0100;
    next_scan();
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_col", {28'd0, col_n}, 32'hE);
    check("mid_rst_code", {28'd0, key_code}, 32'h0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_down", {31'd0, key_down}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'h7);
    scans(2);
    check("k7_not_yet", exp_q.size(), 32'd1);
    next_scan();
    repeat (2) @(negedge clk);
    check("k7_taken", exp_q.size(), 32'd0);
    check("k7_code", {28'd0, key_code}, 32'h7);
    pressed = 16'h0000;
    scans(3);
    repeat (2) @(negedge clk);
    check("k7_released", {31'd0, key_down}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
